// File: rtl/receiver_fifo_if.sv
// rtl/receiver_fifo_if.sv - UART RX FIFO signal bundle
interface receiver_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    fifo_rx_i;
  logic          fifo_rx_perr_i;
  logic          fifo_rx_ferr_i;
  logic          fifo_rx_brk_i;
  logic          fifo_rx_push_i;
  logic          fifo_rx_pop_i;
  logic          fifo_rx_reset_i;
  logic          lsr_read_i;
  logic          char_tick_i;
  logic [1:0]    rx_trig_lvl_i;

  logic [7:0]    fifo_rx_o;
  logic          fifo_rx_perr_o;
  logic          fifo_rx_ferr_o;
  logic          fifo_rx_brk_o;
  logic          fifo_rx_empty_o;
  logic          fifo_rx_full_o;
  logic [CW-1:0] fifo_rx_count_o;
  logic          overrun_o;
  logic          err_in_fifo_o;
  logic          trigger_o;
  logic          timeout_o;

  modport master (
    output fifo_rx_i, fifo_rx_perr_i, fifo_rx_ferr_i, fifo_rx_brk_i,
           fifo_rx_push_i, fifo_rx_pop_i, fifo_rx_reset_i, lsr_read_i,
           char_tick_i, rx_trig_lvl_i,
    input  fifo_rx_o, fifo_rx_perr_o, fifo_rx_ferr_o, fifo_rx_brk_o,
           fifo_rx_empty_o, fifo_rx_full_o, fifo_rx_count_o, overrun_o,
           err_in_fifo_o, trigger_o, timeout_o
  );

  modport slave (
    input  fifo_rx_i, fifo_rx_perr_i, fifo_rx_ferr_i, fifo_rx_brk_i,
           fifo_rx_push_i, fifo_rx_pop_i, fifo_rx_reset_i, lsr_read_i,
           char_tick_i, rx_trig_lvl_i,
    output fifo_rx_o, fifo_rx_perr_o, fifo_rx_ferr_o, fifo_rx_brk_o,
           fifo_rx_empty_o, fifo_rx_full_o, fifo_rx_count_o, overrun_o,
           err_in_fifo_o, trigger_o, timeout_o
  );
endinterface

// File: rtl/receiver_fifo.sv
// rtl/receiver_fifo.sv - UART receive FIFO with per-character error status and LSR/IIR flags
module receiver_fifo #(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic           clk,
  input  logic           reset,
  receiver_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [2:0]    IDLE_MAX = 3'(TIMEOUT_CHARS);

  // Entry layout: {brk, ferr, perr, data[7:0]}
  logic [10:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]    idle_q, idle_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;

  logic          empty, full;
  logic          pop_ok, push_ok, push_lost;
  logic [10:0]   wr_entry, head_entry;
  logic          wr_has_err, head_has_err;
  logic [CW-1:0] trig_level;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_FULL);
  assign wr_entry     = {bus.fifo_rx_brk_i, bus.fifo_rx_ferr_i, bus.fifo_rx_perr_i, bus.fifo_rx_i};
  assign head_entry   = mem_q[rd_ptr_q];
  assign wr_has_err   = |wr_entry[10:8];
  assign head_has_err = |head_entry[10:8];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
  assign pop_ok    = bus.fifo_rx_pop_i && !empty && !bus.fifo_rx_reset_i;
  assign push_ok   = bus.fifo_rx_push_i && !bus.fifo_rx_reset_i && (!full || pop_ok);
  assign push_lost = bus.fifo_rx_push_i && !bus.fifo_rx_reset_i && full && !pop_ok;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    idle_d    = idle_q;
    overrun_d = overrun_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case ({push_ok && wr_has_err, pop_ok && head_has_err})
      2'b10:   err_cnt_d = err_cnt_q + CNT_ONE;
      2'b01:   err_cnt_d = err_cnt_q - CNT_ONE;
      default: err_cnt_d = err_cnt_q;
    endcase

    if (push_lost) begin
      overrun_d = 1'b1;
    end else if (bus.lsr_read_i) begin
      overrun_d = 1'b0;
    end

    if (push_ok || pop_ok || empty) begin
      idle_d = 3'd0;
    end else if (bus.char_tick_i && (idle_q < IDLE_MAX)) begin
      idle_d = idle_q + 3'd1;
    end

    // Flush empties the FIFO but leaves the sticky overrun for software to see.
    if (bus.fifo_rx_reset_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
      idle_d    = 3'd0;
    end

    timeout_d = (count_d != '0) && (idle_d == IDLE_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      idle_q    <= 3'd0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      idle_q    <= idle_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    trig_level = CW'(1);
    case (bus.rx_trig_lvl_i)
      2'b00: trig_level = CW'(1);
      2'b01: trig_level = CW'(4);
      2'b10: trig_level = CW'(8);
      2'b11: trig_level = CW'(14);
      default: trig_level = CW'(1);
    endcase
  end

  assign bus.fifo_rx_o       = empty ? 8'h00 : head_entry[7:0];
  assign bus.fifo_rx_perr_o  = !empty && head_entry[8];
  assign bus.fifo_rx_ferr_o  = !empty && head_entry[9];
  assign bus.fifo_rx_brk_o   = !empty && head_entry[10];
  assign bus.fifo_rx_empty_o = empty;
  assign bus.fifo_rx_full_o  = full;
  assign bus.fifo_rx_count_o = count_q;
  assign bus.overrun_o       = overrun_q;
  assign bus.err_in_fifo_o   = (err_cnt_q != '0);
  assign bus.trigger_o       = (count_q >= trig_level);
  assign bus.timeout_o       = timeout_q;
endmodule

// File: tb/tb_receiver_fifo.sv
// tb/tb_receiver_fifo.sv - self-checking bench for receiver_fifo
module tb_receiver_fifo;
  localparam int DEPTH    = 16;
  localparam int TO_CHARS = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  receiver_fifo_if #(.DEPTH(DEPTH)) ifc ();

  receiver_fifo #(.DEPTH(DEPTH), .TIMEOUT_CHARS(TO_CHARS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: an ordered queue of stored entries plus the sticky/idle state.
  logic [10:0] mq[$];
  bit          m_ovr;
  int          m_idle;
  bit          m_to;
  int          trig_tab[4] = '{1, 4, 8, 14};

  typedef struct {
    bit          push, pop, flush, tick;
    bit [1:0]    lvl;
    logic [10:0] ent;
    int          cnt;
    bit [7:0]    head;
    bit          err, trig, to;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_strobes();
    ifc.fifo_rx_push_i  = 1'b0;
    ifc.fifo_rx_pop_i   = 1'b0;
    ifc.fifo_rx_reset_i = 1'b0;
    ifc.lsr_read_i      = 1'b0;
    ifc.char_tick_i     = 1'b0;
  endtask

  task automatic model_step(input bit push, pop, flush, lsr, tick, input logic [10:0] ent);
    bit was_empty, was_full, pop_ok, push_ok, lost;
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    pop_ok    = pop && !was_empty && !flush;
    push_ok   = push && !flush && (!was_full || pop_ok);
    lost      = push && !flush && was_full && !pop_ok;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(ent);
    end
    if (lost) m_ovr = 1'b1;
    else if (lsr) m_ovr = 1'b0;
    if (flush || push_ok || pop_ok || was_empty) m_idle = 0;
    else if (tick && m_idle < TO_CHARS) m_idle++;
    m_to = (mq.size() != 0) && (m_idle == TO_CHARS);
  endtask

  task automatic cyc(input bit push, pop, flush, lsr, tick, input logic [10:0] ent);
    @(negedge clk);
    ifc.fifo_rx_push_i  = push;
    ifc.fifo_rx_pop_i   = pop;
    ifc.fifo_rx_reset_i = flush;
    ifc.lsr_read_i      = lsr;
    ifc.char_tick_i     = tick;
    ifc.fifo_rx_i       = ent[7:0];
    ifc.fifo_rx_perr_i  = ent[8];
    ifc.fifo_rx_ferr_i  = ent[9];
    ifc.fifo_rx_brk_i   = ent[10];
    @(posedge clk);
    model_step(push, pop, flush, lsr, tick, ent);
    #1;
    clear_strobes();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_strobes();
    reset = 1'b1;
    @(posedge clk);
    mq.delete();
    m_ovr  = 1'b0;
    m_idle = 0;
    m_to   = 1'b0;
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [10:0] h;
    bit          any_err;
    h = (mq.size() != 0) ? mq[0] : 11'h000;
    any_err = 1'b0;
    foreach (mq[i]) if (mq[i][10:8] != 3'b000) any_err = 1'b1;
    chk({tag, ".count"}, 32'(ifc.fifo_rx_count_o), mq.size());
    chk({tag, ".empty"}, 32'(ifc.fifo_rx_empty_o), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(ifc.fifo_rx_full_o),  32'(mq.size() == DEPTH));
    chk({tag, ".data"},  32'(ifc.fifo_rx_o),       32'(h[7:0]));
    chk({tag, ".flags"}, 32'({ifc.fifo_rx_brk_o, ifc.fifo_rx_ferr_o, ifc.fifo_rx_perr_o}), 32'(h[10:8]));
    chk({tag, ".ovr"},   32'(ifc.overrun_o),       32'(m_ovr));
    chk({tag, ".err"},   32'(ifc.err_in_fifo_o),   32'(any_err));
    chk({tag, ".trig"},  32'(ifc.trigger_o),       32'(int'(mq.size()) >= trig_tab[ifc.rx_trig_lvl_i]));
    chk({tag, ".to"},    32'(ifc.timeout_o),       32'(m_to));
  endtask

  initial begin
    clear_strobes();
    ifc.fifo_rx_i      = 8'h00;
    ifc.fifo_rx_perr_i = 1'b0;
    ifc.fifo_rx_ferr_i = 1'b0;
    ifc.fifo_rx_brk_i  = 1'b0;
    ifc.rx_trig_lvl_i  = 2'b00;

    //          push pop fl tick lvl ent       cnt head   err trig to
    vt.push_back('{1, 0, 0, 0, 0, 11'h041, 1, 8'h41, 0, 1, 0});
    vt.push_back('{1, 0, 0, 0, 0, 11'h042, 2, 8'h41, 0, 1, 0});
    vt.push_back('{1, 0, 0, 0, 0, 11'h043, 3, 8'h41, 0, 1, 0});
    vt.push_back('{0, 1, 0, 0, 0, 11'h000, 2, 8'h42, 0, 1, 0});
    vt.push_back('{0, 1, 0, 0, 0, 11'h000, 1, 8'h43, 0, 1, 0});
    vt.push_back('{0, 1, 0, 0, 0, 11'h000, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 0, 11'h010, 1, 8'h10, 0, 1, 0});
    vt.push_back('{1, 0, 0, 0, 0, 11'h220, 2, 8'h10, 1, 1, 0});
    vt.push_back('{1, 0, 0, 0, 0, 11'h030, 3, 8'h10, 1, 1, 0});
    vt.push_back('{0, 1, 0, 0, 0, 11'h000, 2, 8'h20, 1, 1, 0});
    vt.push_back('{0, 1, 0, 0, 0, 11'h000, 1, 8'h30, 0, 1, 0});
    vt.push_back('{0, 1, 0, 0, 0, 11'h000, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 1, 11'h001, 1, 8'h01, 0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 1, 11'h002, 2, 8'h01, 0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 1, 11'h003, 3, 8'h01, 0, 0, 0});
    vt.push_back('{1, 0, 0, 0, 1, 11'h004, 4, 8'h01, 0, 1, 0});
    vt.push_back('{0, 0, 0, 0, 2, 11'h000, 4, 8'h01, 0, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 4, 8'h01, 0, 1, 0});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 4, 8'h01, 0, 1, 0});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 4, 8'h01, 0, 1, 0});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 4, 8'h01, 0, 1, 1});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 4, 8'h01, 0, 1, 1});
    vt.push_back('{0, 1, 0, 0, 0, 11'h000, 3, 8'h02, 0, 1, 0});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 3, 8'h02, 0, 1, 0});
    vt.push_back('{0, 0, 1, 0, 0, 11'h000, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 0, 8'h00, 0, 0, 0});
    vt.push_back('{0, 0, 0, 1, 0, 11'h000, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 1, 0, 0, 0, 11'h455, 1, 8'h55, 1, 1, 0});
    vt.push_back('{0, 1, 0, 0, 0, 11'h000, 0, 8'h00, 0, 0, 0});
    vt.push_back('{1, 0, 1, 0, 0, 11'h077, 0, 8'h00, 0, 0, 0});

    do_reset();
    chk("rst.count", 32'(ifc.fifo_rx_count_o), 0);
    chk("rst.empty", 32'(ifc.fifo_rx_empty_o), 1);
    chk("rst.full",  32'(ifc.fifo_rx_full_o), 0);
    chk("rst.ovr",   32'(ifc.overrun_o), 0);
    chk("rst.to",    32'(ifc.timeout_o), 0);

    foreach (vt[i]) begin
      ifc.rx_trig_lvl_i = vt[i].lvl;
      cyc(vt[i].push, vt[i].pop, vt[i].flush, 1'b0, vt[i].tick, vt[i].ent);
      chk($sformatf("vec%0d.count", i), 32'(ifc.fifo_rx_count_o), vt[i].cnt);
      chk($sformatf("vec%0d.empty", i), 32'(ifc.fifo_rx_empty_o), 32'(vt[i].cnt == 0));
      chk($sformatf("vec%0d.full", i),  32'(ifc.fifo_rx_full_o),  32'(vt[i].cnt == DEPTH));
      chk($sformatf("vec%0d.head", i),  32'(ifc.fifo_rx_o),       32'(vt[i].head));
      chk($sformatf("vec%0d.err", i),   32'(ifc.err_in_fifo_o),   32'(vt[i].err));
      chk($sformatf("vec%0d.trig", i),  32'(ifc.trigger_o),       32'(vt[i].trig));
      chk($sformatf("vec%0d.to", i),    32'(ifc.timeout_o),       32'(vt[i].to));
    end

    // Trigger follows the level select without a clock edge.
    ifc.rx_trig_lvl_i = 2'b00;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'(8'h60 + i));
    chk("trig.lvl8", 32'(ifc.trigger_o), 1);
    #1 ifc.rx_trig_lvl_i = 2'b11;
    #1 chk("trig.lvl14", 32'(ifc.trigger_o), 0);
    ifc.rx_trig_lvl_i = 2'b00;

    // Fill, overrun, LSR clear, set-wins, push+pop while full, flush holds overrun.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'(8'h80 + i));
    chk("fill.full", 32'(ifc.fifo_rx_full_o), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h099);
    chk("ovr.set", 32'(ifc.overrun_o), 1);
    chk("ovr.head", 32'(ifc.fifo_rx_o), 32'h80);
    chk("ovr.count", 32'(ifc.fifo_rx_count_o), DEPTH);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000);
    chk("ovr.clr", 32'(ifc.overrun_o), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h09A);
    chk("ovr.setwins", 32'(ifc.overrun_o), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h09B);
    chk("fullpp.count", 32'(ifc.fifo_rx_count_o), DEPTH);
    chk("fullpp.ovr", 32'(ifc.overrun_o), 0);
    chk("fullpp.head", 32'(ifc.fifo_rx_o), 32'h81);
    check_all("fullpp");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h09C);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
    chk("flush.ovr", 32'(ifc.overrun_o), 1);
    chk("flush.count", 32'(ifc.fifo_rx_count_o), 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'(11'h700 + i));
    check_all("five");
    do_reset();
    chk("rst5.count", 32'(ifc.fifo_rx_count_o), 0);
    chk("rst5.empty", 32'(ifc.fifo_rx_empty_o), 1);
    chk("rst5.head",  32'(ifc.fifo_rx_o), 0);
    chk("rst5.flags", 32'({ifc.fifo_rx_brk_o, ifc.fifo_rx_ferr_o, ifc.fifo_rx_perr_o}), 0);
    chk("rst5.ovr",   32'(ifc.overrun_o), 0);
    chk("rst5.err",   32'(ifc.err_in_fifo_o), 0);

    // Randomized traffic against the queue model, alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 4000; i++) begin
      bit          rp, rq, rf, rl, rt;
      logic [10:0] re;
      int          push_pct;
      push_pct = ((i / 400) % 2 == 0) ? 75 : 35;
      rp = ($urandom_range(99) < push_pct);
      rq = ($urandom_range(99) < 100 - push_pct);
      rf = ($urandom_range(299) == 0);
      rl = ($urandom_range(9) == 0);
      rt = ($urandom_range(2) == 0);
      re = 11'($urandom);
      if ($urandom_range(3) != 0) re[10:8] = 3'b000;
      if ($urandom_range(49) == 0) ifc.rx_trig_lvl_i = 2'($urandom);
      if ((i / 200) % 5 == 4) begin
        rp = 1'b0;
        rq = 1'b0;
      end
      cyc(rp, rq, rf, rl, rt, re);
      check_all($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
